// File: rtl/unsigned_approx_mul_pipe.sv
// Two-stage N x N unsigned multiplier with a per-transaction exact/approximate mode; the approximate mode truncates the low L rows of x.
// Latency 2 cycles. Valid/ready on both sides, with in_ready taken combinationally from out_ready (no skid buffer).
module unsigned_approx_mul_pipe #(
  parameter int N  = 8,
  parameter int L  = 2,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_x,
  input  logic [N-1:0]    in_y,
  input  logic            in_exact,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_z,
  output logic            out_exact,
  input  logic            cnt_clr,
  output logic [CW-1:0]   approx_cnt
);

  localparam int W = 2 * N;

  logic          s1_en, s2_en;
  logic          s1_valid_q, s1_exact_q;
  logic [W-1:0]  s1_hi_d, s1_lo_d, s1_c_d;
  logic [W-1:0]  s1_hi_q, s1_lo_q, s1_c_q;
  logic          or_term;
  logic          out_valid_q, out_exact_q;
  logic [W-1:0]  out_z_d, out_z_q;
  logic [CW-1:0] cnt_d, cnt_q;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // hi: rows L..N-1, identical in both modes. lo: exact low rows. c: truncated low rows.
  always_comb begin
    s1_hi_d = (W'(in_y) * W'(in_x >> L)) << L;
    s1_lo_d = '0;
    s1_c_d  = '0;
    or_term = 1'b0;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < N; j++) begin
        if (in_x[i] && in_y[j]) begin
          s1_lo_d = s1_lo_d + (W'(1) << (i + j));
          if (i + j >= N - 1) s1_c_d = s1_c_d + (W'(1) << (i + j));
          if (i + j == N - 2) or_term = 1'b1;
        end
      end
    end
    s1_c_d = s1_c_d + (W'(or_term) << (N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_exact_q <= 1'b0;
      s1_hi_q    <= '0;
      s1_lo_q    <= '0;
      s1_c_q     <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_exact_q <= in_exact;
        s1_hi_q    <= s1_hi_d;
        s1_lo_q    <= s1_lo_d;
        s1_c_q     <= s1_c_d;
      end
    end
  end

  assign out_z_d = s1_hi_q + (s1_exact_q ? s1_lo_q : s1_c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_exact_q <= 1'b0;
      out_z_q     <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_exact_q <= s1_exact_q;
        out_z_q     <= out_z_d;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && !out_exact_q && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid  = out_valid_q;
  assign out_exact  = out_exact_q;
  assign out_z      = out_z_q;
  assign approx_cnt = cnt_q;

endmodule
